// File: rtl/pulse_width_capture.sv
// pulse_width_capture
//
// Measures how many clk cycles a (possibly asynchronous) input stays high
// and hands the result to a consumer over a valid/ack handshake. It is the
// inverse of the compare timer: the timer turns a count into an interval,
// this block turns an observed interval back into a count.
//
// Parameters
//   W            counter/result width; results saturate at 2^W-1
//   SYNC_STAGES  synchronizer depth on sig_in (>= 1)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   sig_in     pulse to measure, may be asynchronous to clk
//   ack        consumer accepts width_out/sat_out while valid is high
//   width_out  captured high time in clk cycles (saturated)
//   sat_out    captured pulse lasted 2^W-1 cycles or more (possibly truncated)
//   valid      width_out/sat_out hold an unacknowledged measurement
//   overrun    sticky: a finished measurement was dropped because valid was high
//   busy       a pulse is currently being measured
module pulse_width_capture #(
    parameter int W           = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sig_in,
    input  logic         ack,
    output logic [W-1:0] width_out,
    output logic         sat_out,
    output logic         valid,
    output logic         overrun,
    output logic         busy
);

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    localparam logic [W-1:0] CNT_ONE  = W'(1);
    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam logic [W-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

    state_t                 state_q,   state_d;
    logic [SYNC_STAGES-1:0] sync_q,    sync_d;
    logic [SYNC_STAGES-1:0] fill_q,    fill_d;
    logic                   s_prev_q,  s_prev_d;
    logic [W-1:0]           count_q,   count_d;
    logic                   sat_q,     sat_d;
    logic [W-1:0]           width_q,   width_d;
    logic                   sat_out_q, sat_out_d;
    logic                   valid_q,   valid_d;
    logic                   overrun_q, overrun_d;

    logic s;
    logic rise;

    // fill_q marks which synchronizer stages hold real pin samples. Until the
    // last stage does, s reads as high, so a pin that is already high when
    // reset releases never looks like a rise; a real low must be seen first.
    assign s    = sync_q[SYNC_STAGES-1] | ~fill_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev_q;

    always_comb begin
        // NOTE: every signal written here gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        sync_d    = sync_q;
        fill_d    = fill_q;
        state_d   = state_q;
        count_d   = count_q;
        sat_d     = sat_q;
        width_d   = width_q;
        sat_out_d = sat_out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        s_prev_d  = s;

        sync_d[0] = sig_in;
        fill_d[0] = 1'b1;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
            fill_d[i] = fill_q[i-1];
        end

        // Ack with nothing pending is ignored; a capture below overrides this.
        if (valid_q && ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    count_d = CNT_ONE;
                    sat_d   = (CNT_ONE == CNT_MAX);
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (s) begin
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_ONE;
                    end
                    // Flag as soon as the count reaches the ceiling, so an
                    // exact 2^W-1 pulse is reported as possibly truncated.
                    if (count_q >= CNT_NEAR) begin
                        sat_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    if (!valid_q || ack) begin
                        width_d   = count_q;
                        sat_out_d = sat_q;
                        valid_d   = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            fill_q    <= '0;
            s_prev_q  <= 1'b1;
            count_q   <= '0;
            sat_q     <= 1'b0;
            width_q   <= '0;
            sat_out_q <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            fill_q    <= fill_d;
            s_prev_q  <= s_prev_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            width_q   <= width_d;
            sat_out_q <= sat_out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign width_out = width_q;
    assign sat_out   = sat_out_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == MEAS);

endmodule

// File: doc/pulse_width_capture.md
Name: pulse_width_capture

Overview:
- Inverse of the 6-bit compare timer: the timer turns a programmed count into an interval; this block turns an observed interval back into a count.
- Measures the high time of a single-bit input in clk cycles.
- Presents the result on a valid/ack handshake.
- Sits beside the timer so software or an upstream FSM can check a generated pulse width, or time external strobes.

Parameters:
- W, 6: counter and result width in bits; the result saturates at 2^W-1.
- SYNC_STAGES, 2: synchronizer flops on sig_in, minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- sig_in  input  1  pulse to measure; may be asynchronous to clk.
- ack  input  1  consumer accepts width_out when high while valid is high.
- width_out  output  W  captured high time in clk cycles.
- sat_out  output  1  captured pulse reached or exceeded 2^W-1 cycles.
- valid  output  1  width_out and sat_out hold a measurement not yet acknowledged.
- overrun  output  1  sticky; a completed measurement was dropped because valid was still high.
- busy  output  1  high while in state MEAS.

Behaviour:
- Reset (async, active-high):
  - Outputs: width_out=0, sat_out=0, valid=0, overrun=0, busy=0.
  - Internal state: state=IDLE, count=0, synchronizer flops=0, edge register s_d=1.
  - s_d=1 means a sig_in already high when reset releases is not measured. The block waits for a falling then rising edge.
- Synchronizer: s is sig_in delayed by SYNC_STAGES flops. Every timing rule below is stated in terms of s.
- Edge register: s_d <= s every cycle. Rise = s&~s_d. Fall = ~s&s_d.
- FSM states: IDLE, MEAS.
  - IDLE: on rise, count<=1, sat<=0, go to MEAS. Otherwise hold.
  - MEAS, s==1: count<=count+1.
    - If count==2^W-1, count holds and sat<=1.
    - count never wraps.
  - MEAS, s==0 (fall): capture and return to IDLE in the same edge.
- Result convention: a pulse with s high for exactly N consecutive cycles yields width_out=N for N<2^W-1, sat_out=0.
  - N>=2^W-1 yields width_out=2^W-1, sat_out=1.
  - N=2^W-1 exactly also sets sat_out=1, so the flag means "possibly truncated".
- Capture, on fall in MEAS:
  - If valid==0, or ack==1 in that same cycle: width_out<=count, sat_out<=sat, valid<=1.
  - Else: width_out and sat_out are unchanged, and overrun<=1.
- Handshake:
  - valid clears on the cycle after ack is sampled high with valid high, unless a capture occurs in that same cycle; then valid stays 1 with the new data.
  - ack while valid==0 is ignored.
  - width_out and sat_out are stable while valid==1.
- overrun: cleared only by reset. It does not gate further captures.
- Latency: valid rises 1 clk after the cycle in which s is first sampled low, which is SYNC_STAGES+1 clks after sig_in falls at the pin.
- Back-to-back pulses:
  - A rise may occur on the cycle after the capture edge, since the FSM is already back in IDLE.
  - The minimum low gap of 1 cycle is measurable.
  - High time of 1 cycle gives width_out=1.
- Reset mid-measurement: the measurement is discarded and the block returns to the reset state. The pulse still high at release is ignored (s_d=1 rule).
- busy = (state==MEAS).

Test Plan:
- Reset release with sig_in low; drive sig_in high 5 clks then low -> after SYNC_STAGES+1 clks from the fall: valid=1, width_out=5, sat_out=0; busy was high for exactly 5 cycles.
- Pulse high 70 clks, W=6 -> width_out=63, sat_out=1, valid=1; count never wraps to 0.
- Pulse of 3 clks, no ack, then pulse of 9 clks -> width_out stays 3, overrun=1. Ack -> valid=0 next cycle; a following 4-clk pulse -> width_out=4, overrun still 1.
- Ack asserted in the exact cycle a new 7-clk pulse is captured, with previous width_out=2 pending -> valid stays 1, width_out=7, overrun=0.
- sig_in held high through reset, released, high 10 more clks, then low -> no valid. Next 6-clk pulse -> width_out=6.
- Assert reset at cycle 4 of a 12-clk pulse -> all outputs 0 immediately (async). The pulse's remainder produces no valid. The next 1-clk pulse gives width_out=1.
